// File: rtl/adc_frontend_pkg.sv
// Shared types, constants and helpers for the ADC front-end aligner.
// Pure declarations: no state, no latency.
package adc_frontend_pkg;

    typedef enum logic [1:0] {
        CAL_IDLE,
        CAL_ACC,
        CAL_DONE
    } cal_state_t;

    localparam int PIPE_LAT = 3;

    // Clamp a wide signed value into the two's complement range of 'width' bits.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] x, input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/tag_delay_line.sv
// 1-bit shift register of depth 2**DEL_BITS with a runtime-selected tap.
// tag_out is combinational from the line (tap 0 = tag_in delayed one cycle); no backpressure.
module tag_delay_line #(
    parameter int DEL_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tag_in,
    input  logic [DEL_BITS-1:0] tap_sel,
    output logic                tag_out
);
    localparam int DEPTH = 2 ** DEL_BITS;

    logic [DEPTH-1:0] line_q;
    logic [DEPTH-1:0] line_d;

    always_comb begin
        line_d = {line_q[DEPTH-2:0], tag_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign tag_out = line_q[tap_sel];

endmodule

// File: rtl/adc_frontend_aligner.sv
// Per-channel ADC conditioning: offset removal with saturation, boxcar mean, run-tag re-timing, baseline calibration.
// Fixed 3-cycle sample latency, val_valid delayed a further del_cfg cycles; free-running, no backpressure.
module adc_frontend_aligner
    import adc_frontend_pkg::*;
#(
    parameter int NUM_BITS = 16,
    parameter int DEL_BITS = 8,
    parameter int AVG_LOG  = 2,
    parameter int CAL_LOG  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [NUM_BITS-1:0] adc_tdata,
    input  logic                       adc_tvalid,
    input  logic                       run,
    input  logic        [DEL_BITS-1:0] del_cfg,
    input  logic                       avg_en,
    input  logic                       cal_trig,
    input  logic                       sat_clr,
    output logic signed [NUM_BITS-1:0] val_out,
    output logic                       val_valid,
    output logic signed [NUM_BITS-1:0] offset,
    output logic                       cal_busy,
    output logic                       cal_done,
    output logic        [15:0]         sat_count
);
    localparam int SUM_W  = NUM_BITS + AVG_LOG;
    localparam int ACC_W  = NUM_BITS + CAL_LOG;
    localparam int HIST_N = 2 ** AVG_LOG;

    logic signed [NUM_BITS-1:0]          s1_q, s1_d;
    logic                                s1_vld_q, s1_vld_d;
    logic signed [NUM_BITS-1:0]          corr_q, corr_d;
    logic [HIST_N-1:0][NUM_BITS-1:0]     hist_q, hist_d;
    logic signed [SUM_W-1:0]             sum_q, sum_d;
    logic signed [NUM_BITS-1:0]          val_out_q, val_out_d;
    logic [PIPE_LAT-2:0]                 tag_pipe_q, tag_pipe_d;
    logic                                tag_tap;
    logic [15:0]                         sat_count_q, sat_count_d;
    logic signed [31:0]                  diff_w;
    logic signed [31:0]                  sat_w;
    logic                                sat_hit;

    cal_state_t                          state_q, state_d;
    logic signed [ACC_W-1:0]             acc_q, acc_d;
    logic [CAL_LOG-1:0]                  cnt_q, cnt_d;
    logic signed [NUM_BITS-1:0]          offset_q, offset_d;
    logic                                cal_trig_q;
    logic                                cal_busy_q, cal_busy_d;
    logic                                cal_done_q, cal_done_d;

    // The run line contributes the first of the PIPE_LAT stages; tag_pipe supplies the rest.
    tag_delay_line #(
        .DEL_BITS (DEL_BITS)
    ) u_tag_line (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (run),
        .tap_sel (del_cfg),
        .tag_out (tag_tap)
    );

    always_comb begin
        s1_d     = adc_tvalid ? adc_tdata : '0;
        s1_vld_d = adc_tvalid;

        diff_w  = 32'(s1_q) - 32'(offset_q);
        sat_w   = saturate(diff_w, NUM_BITS);
        sat_hit = (sat_w != diff_w);
        corr_d  = sat_w[NUM_BITS-1:0];

        // History tracks corr regardless of avg_en so toggling it never shows a stale window.
        hist_d = {hist_q[HIST_N-2:0], corr_d};
        sum_d  = sum_q + SUM_W'(corr_d) - SUM_W'($signed(hist_q[HIST_N-1]));

        val_out_d  = avg_en ? sum_q[SUM_W-1:AVG_LOG] : corr_q;
        tag_pipe_d = {tag_pipe_q[PIPE_LAT-3:0], tag_tap};

        sat_count_d = sat_count_q;
        if (sat_clr) begin
            sat_count_d = '0;
        end else if (sat_hit && (sat_count_q != 16'hFFFF)) begin
            sat_count_d = sat_count_q + 16'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        offset_d   = offset_q;
        cal_done_d = 1'b0;
        case (state_q)
            CAL_IDLE: begin
                if (cal_trig && !cal_trig_q && !run) begin
                    state_d = CAL_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            CAL_ACC: begin
                if (run) begin
                    state_d = CAL_IDLE;
                end else if (s1_vld_q) begin
                    acc_d = acc_q + ACC_W'(s1_q);
                    cnt_d = cnt_q + CAL_LOG'(1);
                    if (&cnt_q) begin
                        state_d = CAL_DONE;
                    end
                end
            end
            CAL_DONE: begin
                offset_d   = acc_q[ACC_W-1:CAL_LOG];
                cal_done_d = 1'b1;
                state_d    = CAL_IDLE;
            end
            default: begin
                state_d = CAL_IDLE;
            end
        endcase
        cal_busy_d = (state_d == CAL_ACC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s1_vld_q    <= 1'b0;
            corr_q      <= '0;
            hist_q      <= '0;
            sum_q       <= '0;
            val_out_q   <= '0;
            tag_pipe_q  <= '0;
            sat_count_q <= '0;
        end else begin
            s1_q        <= s1_d;
            s1_vld_q    <= s1_vld_d;
            corr_q      <= corr_d;
            hist_q      <= hist_d;
            sum_q       <= sum_d;
            val_out_q   <= val_out_d;
            tag_pipe_q  <= tag_pipe_d;
            sat_count_q <= sat_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CAL_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            offset_q   <= '0;
            cal_trig_q <= 1'b0;
            cal_busy_q <= 1'b0;
            cal_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            offset_q   <= offset_d;
            cal_trig_q <= cal_trig;
            cal_busy_q <= cal_busy_d;
            cal_done_q <= cal_done_d;
        end
    end

    assign val_out   = val_out_q;
    assign val_valid = tag_pipe_q[PIPE_LAT-2];
    assign offset    = offset_q;
    assign cal_busy  = cal_busy_q;
    assign cal_done  = cal_done_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_adc_frontend_aligner.sv
// Bench for adc_frontend_aligner: directed scenarios plus random traffic against a cycle-indexed history model.
module tb_adc_frontend_aligner;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] adc_tdata;
    logic               adc_tvalid;
    logic               run;
    logic [7:0]         del_cfg;
    logic               avg_en;
    logic               cal_trig;
    logic               sat_clr;
    logic signed [15:0] val_out;
    logic               val_valid;
    logic signed [15:0] offset;
    logic               cal_busy;
    logic               cal_done;
    logic [15:0]        sat_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adc_frontend_aligner #(
        .NUM_BITS (16),
        .DEL_BITS (8),
        .AVG_LOG  (2),
        .CAL_LOG  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .adc_tdata  (adc_tdata),
        .adc_tvalid (adc_tvalid),
        .run        (run),
        .del_cfg    (del_cfg),
        .avg_en     (avg_en),
        .cal_trig   (cal_trig),
        .sat_clr    (sat_clr),
        .val_out    (val_out),
        .val_valid  (val_valid),
        .offset     (offset),
        .cal_busy   (cal_busy),
        .cal_done   (cal_done),
        .sat_count  (sat_count)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    // History model: per-edge records indexed by edge number; lr is the latest reset edge.
    localparam int RING = 1024;
    int  s_arr   [RING];
    bit  v_arr   [RING];
    bit  run_arr [RING];
    int  off_arr [RING];
    int  corr_arr[RING];
    int  del_arr [RING];
    int  ec = -1;
    int  lr = 0;
    int  m_mode;
    int  m_n;
    longint m_sum;
    int  m_off;
    int  m_sat;
    bit  m_trig_prev;
    int  e_val;
    bit  e_vld, e_busy, e_done;

    function automatic int ix(input int c);
        return c & (RING - 1);
    endfunction

    always @(posedge clk) begin
        int c, diff, corr, d, sum4;
        bit rise;
        ec++;
        c = ec;
        if (rst) begin
            lr = c;
            s_arr[ix(c)] = 0; v_arr[ix(c)] = 0; run_arr[ix(c)] = 0;
            off_arr[ix(c)] = 0; corr_arr[ix(c)] = 0; del_arr[ix(c)] = int'(del_cfg);
            m_mode = 0; m_off = 0; m_sat = 0; m_trig_prev = 0;
            e_val = 0; e_vld = 0; e_busy = 0; e_done = 0;
        end else begin
            s_arr[ix(c)]   = adc_tvalid ? int'(adc_tdata) : 0;
            v_arr[ix(c)]   = adc_tvalid;
            run_arr[ix(c)] = run;
            del_arr[ix(c)] = int'(del_cfg);
            diff = s_arr[ix(c-1)] - off_arr[ix(c-1)];
            corr = (diff > 32767) ? 32767 : (diff < -32768) ? -32768 : diff;
            corr_arr[ix(c)] = corr;
            if (sat_clr) m_sat = 0;
            else if (corr != diff && m_sat < 65535) m_sat++;
            if (avg_en) begin
                sum4 = 0;
                for (int k = 1; k <= 4; k++) if (c - k > lr) sum4 += corr_arr[ix(c-k)];
                e_val = int'(floor_div(sum4, 4));
            end else begin
                e_val = corr_arr[ix(c-1)];
            end
            d = del_arr[ix(c-1)];
            e_vld = (c - 2 - d > lr) ? run_arr[ix(c-2-d)] : 1'b0;
            rise = cal_trig && !m_trig_prev;
            m_trig_prev = cal_trig;
            e_done = 0;
            case (m_mode)
                0: if (rise && !run) begin m_mode = 1; m_n = 0; m_sum = 0; end
                1: begin
                    if (run) m_mode = 0;
                    else if (v_arr[ix(c-1)]) begin
                        m_sum += s_arr[ix(c-1)];
                        m_n++;
                        if (m_n == 256) m_mode = 2;
                    end
                end
                default: begin m_off = int'(floor_div(m_sum, 256)); e_done = 1; m_mode = 0; end
            endcase
            off_arr[ix(c)] = m_off;
            e_busy = (m_mode == 1);
        end
        #1;
        chk("val_out",   val_out,   e_val);
        chk("val_valid", val_valid, e_vld);
        chk("offset",    offset,    m_off);
        chk("cal_busy",  cal_busy,  e_busy);
        chk("cal_done",  cal_done,  e_done);
        chk("sat_count", sat_count, m_sat);
    end

    task automatic calibrate(input int value, output int busy_cycles, output bit got_done);
        adc_tdata = 16'(value); adc_tvalid = 1; run = 0; cal_trig = 0;
        @(negedge clk);
        cal_trig = 1;
        busy_cycles = 0; got_done = 0;
        for (int k = 0; k < 600 && !got_done; k++) begin
            @(negedge clk);
            if (cal_busy) busy_cycles++;
            if (cal_done) got_done = 1;
        end
        cal_trig = 0;
    endtask

    initial begin
        int nv, vcyc, busy, cnt, maxv;
        bit got;
        logic signed [15:0] vval;

        rst = 1;
        repeat (2) begin
            adc_tdata = 16'($urandom); adc_tvalid = 1'($urandom); run = 1'($urandom);
            del_cfg = 8'($urandom); avg_en = 1'($urandom); cal_trig = 1'($urandom); sat_clr = 1'($urandom);
            @(negedge clk);
        end
        chk("reset_val_out", val_out, 0);
        chk("reset_val_valid", val_valid, 0);
        chk("reset_offset", offset, 0);
        chk("reset_sat_count", sat_count, 0);
        rst = 0; run = 0; cal_trig = 0; sat_clr = 0; avg_en = 0; del_cfg = 8'd5;
        adc_tvalid = 1; adc_tdata = 0;
        repeat (10) @(negedge clk);

        nv = 0; vcyc = -1; vval = 0;
        for (int i = 0; i <= 30; i++) begin
            adc_tdata = 16'(i); run = (i == 10);
            @(negedge clk);
            if (val_valid) begin nv++; vcyc = i + 1; vval = val_out; end
        end
        chk("align_count", nv, 1);
        chk("align_cycle", vcyc, 18);
        chk("align_val", vval, 15);

        calibrate(100, busy, got);
        chk("cal100_busy_cycles", busy, 256);
        chk("cal100_done", got, 1);
        chk("cal100_offset", offset, 100);
        repeat (4) @(negedge clk);
        chk("cal100_val_out", val_out, 0);

        calibrate(-100, busy, got);
        chk("calm100_offset", offset, -100);
        sat_clr = 1; @(negedge clk); sat_clr = 0;
        adc_tdata = 16'sd32760;
        repeat (4) @(negedge clk);
        adc_tdata = 0;
        maxv = -40000;
        repeat (8) begin
            @(negedge clk);
            if (int'(val_out) > maxv) maxv = int'(val_out);
        end
        chk("sat_val_out", maxv, 32767);
        chk("sat_count4", sat_count, 4);
        sat_clr = 1; @(negedge clk); sat_clr = 0;
        chk("sat_cleared", sat_count, 0);

        adc_tdata = 16'sd500; cal_trig = 0;
        @(negedge clk);
        cal_trig = 1;
        @(negedge clk);
        repeat (99) @(negedge clk);
        run = 1;
        @(negedge clk);
        chk("abort_busy", cal_busy, 0);
        cal_trig = 0;
        cnt = 0;
        repeat (300) begin @(negedge clk); if (cal_done) cnt++; end
        chk("abort_no_done", cnt, 0);
        chk("abort_offset", offset, -100);
        cal_trig = 1;
        cnt = 0;
        repeat (8) begin @(negedge clk); if (cal_busy) cnt++; end
        chk("trig_while_run", cnt, 0);
        run = 0;
        cnt = 0;
        repeat (300) begin @(negedge clk); if (cal_busy) cnt++; end
        chk("held_trig_no_retrigger", cnt, 0);
        cal_trig = 0;

        calibrate(0, busy, got);
        chk("cal0_offset", offset, 0);
        avg_en = 1; adc_tdata = 0;
        repeat (6) @(negedge clk);
        adc_tdata = 4;   @(negedge clk);
        adc_tdata = 8;   @(negedge clk);
        adc_tdata = 12;  @(negedge clk);
        adc_tdata = -3;  @(negedge clk);
        adc_tdata = 0;
        repeat (2) @(negedge clk);
        chk("boxcar_mean", val_out, 5);
        repeat (6) @(negedge clk);
        adc_tdata = -1;  @(negedge clk);
        adc_tdata = 0;
        repeat (2) @(negedge clk);
        chk("boxcar_floor", val_out, -1);

        for (int seg = 0; seg < 6; seg++) begin
            for (int ph = 0; ph < 570; ph++) begin
                case ($urandom_range(0, 3))
                    0: adc_tdata = 16'sd32767;
                    1: adc_tdata = -16'sd32768;
                    2: adc_tdata = 16'($urandom_range(0, 400)) - 16'sd200;
                    default: adc_tdata = 16'($urandom);
                endcase
                adc_tvalid = ($urandom_range(0, 9) < 8);
                avg_en     = 1'($urandom);
                sat_clr    = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 63) == 0) cal_trig = ~cal_trig;
                rst        = ($urandom_range(0, 299) == 0);
                run        = (ph >= 270) && ($urandom_range(0, 5) == 0);
                if (ph == 269) del_cfg = (seg == 2) ? 8'd255 : 8'($urandom_range(0, 12));
                @(negedge clk);
            end
        end
        rst = 0; run = 0; sat_clr = 0;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
